main_memory_responder: RTL
==========================

# main_memory_responder

Multi-cycle main-memory model that answers the cache controller's block-refill and write-through requests. It sits on the memory side of the caching system. It accepts a word address plus a read or write strobe, waits a programmable number of cycles, then performs the access. It signals completion on `ready` using a four-phase handshake: it returns a full 4-word block on reads and writes a single 32-bit word on writes.

## Interface
- `address_width`, 10: word-address width; memory depth = 2**address_width words.
- `WIDTH`, 32: data word width.
- `Data_block_width`, 128: refill block width; must equal 4*WIDTH.
- `LATENCY`, 4: access latency in cycles, ≥1.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `address`  in  address_width  word address of the request.
- `read_en`  in  1  block-read request; held until `ready` is seen.
- `write_en`  in  1  word-write request; held until `ready` is seen.
- `write_data`  in  WIDTH  word to write.
- `ready`  out  1  access complete; registered.
- `read_data`  out  Data_block_width  last block read; registered; word 0 is in bits [WIDTH-1:0].

## Operation
- States: IDLE, BUSY, DONE.
- IDLE:
  - If `write_en` or `read_en` is sampled high, latch `address`, `write_data`, and op (write wins if both are high).
  - Load `cnt` = LATENCY-1 and go to BUSY.
- BUSY:
  - Inputs are ignored; latched values are used.
  - If `cnt` != 0, decrement.
  - If `cnt` == 0, perform the access, set `ready` = 1, and go to DONE.
- Access, write: `mem[addr_q]` <= `wdata_q`; `read_data` is unchanged.
- Access, read:
  - base = {addr_q[address_width-1:2], 2'b00}.
  - `read_data` <= {mem[base+3], mem[base+2], mem[base+1], mem[base]}.
  - Offset bits of the address are ignored.
- DONE: `ready` stays 1 while `read_en` or `write_en` is high. When both are low, `ready` <= 0 and the state goes to IDLE.
  - No new request is accepted in the DONE cycle, even if the enables toggle.
- Storage: 2**address_width x WIDTH register array.
  - On reset, `mem[i]` = i (zero-extended) to give a known pattern for refill tests.
- Reset, asynchronous at any time:
  - State = IDLE, `ready` = 0, `read_data` = 0, `cnt` = 0, latches = 0, memory re-initialised.
  - A pending write is aborted and never performed.

## Timing
- Request first sampled high at edge T: `ready` rises after edge T+LATENCY. LATENCY=1 gives `ready` in the cycle after edge T+1.
- `read_data` is valid in the same cycle `ready` first rises. It then holds until the next completed read or reset.
- If the requester drops its enable in the first `ready` cycle, `ready` falls after the next edge (one-cycle pulse).
- A new request can be accepted at the edge after DONE returns to IDLE. Minimum request-to-request spacing is LATENCY+2 edges.
- Changes to `address`, `write_data`, or op during BUSY or DONE have no effect.
- Address wrap: base+3 never exceeds the depth because offset bits are cleared.

## Test plan
- Reset, then read at `address`=0x085, LATENCY=4, with `read_en` held.
  - `ready` = 1 after edge 4.
  - `read_data` = {0x087, 0x086, 0x085, 0x084}.
  - Drop `read_en` in that cycle: `ready` = 0 after the next edge and the state is IDLE.
- Write 0xDEADBEEF to 0x3FE, then read 0x3FC.
  - The write `ready` leaves `read_data` unchanged.
  - The read returns {0x3FF, 0xDEADBEEF, 0x3FD, 0x3FC}.
- Assert `read_en` and `write_en` together, `address`=0x010, data 0x55.
  - The write is performed, `read_data` stays at its previous value, and a subsequent read of 0x010 returns word 0 = 0x55.
- Change `address` and `write_data` every cycle during BUSY.
  - The access uses the values latched at edge T only.
- Assert `reset` two cycles into a write to 0x020 of 0xAA.
  - `ready` = 0 immediately.
  - A later read of 0x020 returns word 0 = 0x020, so the write was aborted.
- LATENCY=1, hold `read_en` for 3 extra cycles after `ready`.
  - `ready` stays high throughout and no second access starts.
  - After release, a new read completes 1 edge after it is sampled.

Source files
------------

// File: rtl/main_memory_responder.sv
// Multi-cycle main-memory model: latches a word-write or block-read request, waits LATENCY
// cycles, performs the access and holds `ready` until the requester drops its enables.
module main_memory_responder #(
  parameter int address_width    = 10,
  parameter int WIDTH            = 32,
  parameter int Data_block_width = 128,
  parameter int LATENCY          = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [address_width-1:0]    address,
  input  logic                        read_en,
  input  logic                        write_en,
  input  logic [WIDTH-1:0]            write_data,
  output logic                        ready,
  output logic [Data_block_width-1:0] read_data
);

  localparam int DEPTH = 2 ** address_width;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                      state_reg, state_next;
  logic [CNT_W-1:0]            cnt_reg, cnt_next;
  logic [address_width-1:0]    addr_reg, addr_next;
  logic [WIDTH-1:0]            wdata_reg, wdata_next;
  logic                        op_write_reg, op_write_next;
  logic                        ready_reg, ready_next;
  logic [Data_block_width-1:0] read_data_reg, read_data_next;
  logic                        mem_we;
  logic [Data_block_width-1:0] block_word;

  // Register array rather than block RAM: reset must restore the mem[i] = i pattern.
  logic [WIDTH-1:0] mem_reg [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= WIDTH'(i);
      end
    end else if (mem_we) begin
      mem_reg[addr_reg] <= wdata_reg;
    end
  end

  // Aligned 4-word block; the two offset bits of the latched address are replaced.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_block
      localparam logic [1:0] OFFSET = 2'(gi);
      assign block_word[gi*WIDTH +: WIDTH] = mem_reg[{addr_reg[address_width-1:2], OFFSET}];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      op_write_reg  <= 1'b0;
      ready_reg     <= 1'b0;
      read_data_reg <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      op_write_reg  <= op_write_next;
      ready_reg     <= ready_next;
      read_data_reg <= read_data_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    op_write_next  = op_write_reg;
    ready_next     = ready_reg;
    read_data_next = read_data_reg;
    mem_we         = 1'b0;

    case (state_reg)
      IDLE: begin
        if (write_en || read_en) begin
          addr_next     = address;
          wdata_next    = write_data;
          op_write_next = write_en;
          cnt_next      = CNT_W'(LATENCY - 1);
          state_next    = BUSY;
        end
      end
      BUSY: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - 1'b1;
        end else begin
          ready_next = 1'b1;
          state_next = DONE;
          if (op_write_reg) begin
            mem_we = 1'b1;
          end else begin
            read_data_next = block_word;
          end
        end
      end
      DONE: begin
        // Completion is held until both enables drop; nothing new is accepted here.
        if (!read_en && !write_en) begin
          ready_next = 1'b0;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        ready_next = 1'b0;
      end
    endcase
  end

  assign ready     = ready_reg;
  assign read_data = read_data_reg;

endmodule
